// File: rtl/src_pkg.sv
// Shared types and constants for the CPU-side memory interface.
package src_pkg;

  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } mem_state_t;

endpackage

// File: rtl/wait_timer.sv
// Counts wait cycles of an outstanding memory access; expired flags the last allowed cycle.
module wait_timer
  import src_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired_q, expired_d;

  // expired tracks the count it is registered with, so it stays a flop output
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    expired_d = (cnt_d == CNT_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/mem_if.sv
// CPU bus to memory bridge: MA/MD registers, read/write handshake with ack timeout.
module mem_if
  import src_pkg::*;
#(
  parameter int unsigned w       = W,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  inout  wire  [w-1:0] bus,
  input  logic         MAin,
  input  logic         MDin,
  input  logic         MDbus,
  input  logic         Read,
  input  logic         Write,
  output logic         busy,
  output logic         done,
  output logic         mem_err,
  output logic [w-1:0] mem_addr,
  output logic [w-1:0] mem_wdata,
  output logic         mem_req,
  output logic         mem_we,
  input  logic [w-1:0] mem_rdata,
  input  logic         mem_ack
);

  mem_state_t   state_q, state_d;
  logic [w-1:0] ma_q, ma_d;
  logic [w-1:0] md_q, md_d;
  logic         busy_q, busy_d;
  logic         we_q, we_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic         expired;

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst),
    .clear   (~busy_q),
    .enable  (busy_q & ~mem_ack),
    .expired (expired)
  );

  // Loads happen before the Read/Write decision so a same-edge request sees new MA/MD
  always_comb begin
    state_d = state_q;
    ma_d    = ma_q;
    md_d    = md_q;
    busy_d  = busy_q;
    we_d    = we_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (MAin) ma_d = bus;
        if (MDin) md_d = bus;
        if (Read && Write) begin
          err_d = 1'b1;
        end else if (Read) begin
          state_d = RD;
          busy_d  = 1'b1;
          we_d    = 1'b0;
        end else if (Write) begin
          state_d = WR;
          busy_d  = 1'b1;
          we_d    = 1'b1;
        end
      end
      RD, WR: begin
        // An ack on the final allowed cycle still wins over the timeout
        if (mem_ack) begin
          if (state_q == RD) md_d = mem_rdata;
          state_d = IDLE;
          busy_d  = 1'b0;
          we_d    = 1'b0;
          done_d  = 1'b1;
        end else if (expired) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ma_q    <= '0;
      md_q    <= '0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ma_q    <= ma_d;
      md_q    <= md_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus       = MDbus ? md_q : 'z;
  assign busy      = busy_q;
  assign mem_req   = busy_q;
  assign mem_we    = we_q;
  assign done      = done_q;
  assign mem_err   = err_q;
  assign mem_addr  = ma_q;
  assign mem_wdata = md_q;

endmodule

// File: tb/tb_mem_if.sv
// Randomized scoreboard bench for mem_if: requests and completions checked by independent monitors.
module tb_mem_if;

  localparam int unsigned T = 16;

  logic        clk = 1'b0;
  logic        rst;
  wire  [31:0] bus;
  logic [31:0] tb_bus;
  logic        tb_drv;
  logic        MAin, MDin, MDbus, Read, Write;
  logic        busy, done, mem_err, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  assign bus = tb_drv ? tb_bus : 'z;

  mem_if #(.w(32), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .MAin(MAin), .MDin(MDin), .MDbus(MDbus), .Read(Read), .Write(Write),
    .busy(busy), .done(done), .mem_err(mem_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    int          cyc;
    logic [31:0] addr;
    logic [31:0] md;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  exp_t exp_q[$];
  req_t req_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference state: what MA and MD must hold, by the architectural rules
  logic [31:0] ma_m = '0;
  logic [31:0] md_m = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Completion monitor: every done/mem_err pulse must match the next scoreboard entry
  always @(negedge clk) begin
    exp_t e;
    if (done || mem_err) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_completion", {30'd0, done, mem_err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("cmpl_kind", {30'd0, done, mem_err}, e.is_done ? 32'd2 : 32'd1);
        chk("cmpl_cycle", 32'(cyc), 32'(e.cyc));
        chk("cmpl_addr", mem_addr, e.addr);
        chk("cmpl_md", mem_wdata, e.md);
      end
    end
  end

  // Request monitor: new requests are checked, then held MA/MD must stay stable
  logic req_prev = 1'b0;
  req_t cur;
  always @(negedge clk) begin
    chk("busy_eq_req", {31'd0, busy}, {31'd0, mem_req});
    if (mem_req && !req_prev) begin
      if (req_q.size() == 0) begin
        chk("unexpected_req", {31'd0, mem_req}, 32'd0);
      end else begin
        cur = req_q.pop_front();
        chk("req_we", {31'd0, mem_we}, {31'd0, cur.we});
        chk("req_addr", mem_addr, cur.addr);
        chk("req_wdata", mem_wdata, cur.wdata);
      end
    end else if (mem_req) begin
      chk("hold_addr", mem_addr, cur.addr);
      chk("hold_wdata", mem_wdata, cur.wdata);
    end
    req_prev = mem_req;
  end

  task automatic clr_inputs();
    MAin = 1'b0; MDin = 1'b0; Read = 1'b0; Write = 1'b0; MDbus = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One wait cycle during a transaction, optionally with inputs that must be ignored
  task automatic wait_cycle(input bit junk);
    if (junk) begin
      tb_bus = (($urandom % 2) == 0) ? 32'h5555_5555 : 32'($urandom);
      MAin = 1'b1; MDin = 1'b1;
      Read = 1'($urandom); Write = 1'($urandom);
    end
    step();
    clr_inputs();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_addr"}, mem_addr, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_ctl"}, {27'd0, busy, done, mem_err, mem_req, mem_we}, 32'd0);
  endtask

  task automatic bus_check();
    tb_drv = 1'b0;
    MDbus  = 1'b1;
    @(negedge clk);
    chk("bus_md", bus, md_m);
    step();
    MDbus  = 1'b0;
    tb_drv = 1'b1;
  endtask

  // d = cycle index within the request at which ack is returned; d >= T means never
  task automatic do_op(input bit la, input logic [31:0] a, input bit lm, input logic [31:0] m,
                       input bit rd, input bit wr, input int d, input logic [31:0] rdat,
                       input bit junk, input bit idle_ack);
    int c0;
    if (la) begin
      tb_bus = a; MAin = 1'b1;
      step();
      MAin = 1'b0;
      ma_m = a;
    end
    tb_bus = m; MDin = lm; Read = rd; Write = wr;
    step();
    clr_inputs();
    c0 = cyc;
    if (lm) md_m = m;
    if (rd && wr) begin
      exp_q.push_back('{is_done: 1'b0, cyc: c0, addr: ma_m, md: md_m});
    end else if (rd || wr) begin
      req_q.push_back('{we: wr, addr: ma_m, wdata: md_m});
      if (d < int'(T)) begin
        repeat (d) wait_cycle(junk);
        if (rd) md_m = rdat;
        exp_q.push_back('{is_done: 1'b1, cyc: c0 + d + 1, addr: ma_m, md: md_m});
        mem_rdata = rdat; mem_ack = 1'b1;
        step();
        mem_ack = 1'b0; mem_rdata = $urandom;
      end else begin
        exp_q.push_back('{is_done: 1'b0, cyc: c0 + int'(T), addr: ma_m, md: md_m});
        repeat (T) wait_cycle(junk);
      end
    end
    if (idle_ack) begin
      mem_ack = 1'b1; mem_rdata = $urandom;
      step();
      mem_ack = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; tb_drv = 1'b1; tb_bus = '0;
    clr_inputs();
    mem_ack = 1'b0; mem_rdata = '0;
    #2;
    chk_reset_outputs("reset_init");
    #10 rst = 1'b1;
    step();

    // Directed cases
    do_op(1'b1, 32'h0000_0100, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 3, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("busy_after_write", {31'd0, busy}, 32'd0);
    step();
    do_op(1'b1, 32'h0000_0200, 1'b0, 32'h0, 1'b1, 1'b0, 0, 32'h0101_0101, 1'b0, 1'b0);
    bus_check();
    do_op(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, int'(T), 32'hFFFF_FFFF, 1'b0, 1'b0);
    @(negedge clk);
    chk("idle_after_timeout", {31'd0, busy}, 32'd0);
    step();
    do_op(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 0, 32'h0, 1'b0, 1'b0);
    do_op(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 4, 32'h0, 1'b1, 1'b1);
    do_op(1'b1, 32'h0000_0444, 1'b0, 32'h0, 1'b1, 1'b0, int'(T) - 1, 32'hCAFE_F00D, 1'b1, 1'b0);
    do_op(1'b0, 32'h0, 1'b1, 32'h1234_5678, 1'b0, 1'b1, int'(T) - 1, 32'h0, 1'b0, 1'b0);

    // Reset in the middle of a read after two wait cycles
    tb_bus = 32'h0000_0300; MAin = 1'b1; Read = 1'b1;
    step();
    clr_inputs();
    ma_m = 32'h0000_0300;
    req_q.push_back('{we: 1'b0, addr: ma_m, wdata: md_m});
    step();
    step();
    tb_bus = 32'hA5A5_0F0F;
    rst = 1'b0;
    #1;
    chk_reset_outputs("reset_mid");
    chk("bus_released", bus, 32'hA5A5_0F0F);
    ma_m = '0; md_m = '0;
    @(negedge clk);
    rst = 1'b1;
    step();
    step();

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      int sel;
      bit rd, wr;
      sel = $urandom_range(0, 9);
      rd = (sel == 0) || (sel >= 2 && sel <= 5);
      wr = (sel == 0) || (sel >= 6);
      do_op(1'($urandom), $urandom, 1'($urandom), $urandom, rd, wr,
            (($urandom % 4) == 0) ? $urandom_range(T - 1, T) : $urandom_range(0, T + 1),
            $urandom, 1'($urandom), (($urandom % 4) == 0));
      if (($urandom % 4) == 0) bus_check();
    end

    repeat (4) step();
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("req_q_drained", 32'(req_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
